// File: rtl/ex_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ex_pkg
// Brief   : Shared widths, stall encoding, ALU/MD opcodes and EX bus types.
// Revision: 1.0 - initial release
// ============================================================================
package ex_pkg;

   localparam int ID_TO_EX_WD  = 147;
   localparam int EX_TO_MEM_WD = 76;
   localparam int EX_TO_ID_WD  = 38;
   localparam int STALL_WD     = 6;

   // Stall vector bit positions and polarity
   localparam int   STALL_EX  = 2;
   localparam int   STALL_MEM = 3;
   localparam logic STOP      = 1'b1;
   localparam logic NO_STOP   = 1'b0;

   // ALU operation codes
   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_NOR  = 4'd5;
   localparam logic [3:0] ALU_SLL  = 4'd6;
   localparam logic [3:0] ALU_SRL  = 4'd7;
   localparam logic [3:0] ALU_SRA  = 4'd8;
   localparam logic [3:0] ALU_SLT  = 4'd9;
   localparam logic [3:0] ALU_SLTU = 4'd10;
   localparam logic [3:0] ALU_LUI  = 4'd11;
   localparam logic [3:0] ALU_MFHI = 4'd12;
   localparam logic [3:0] ALU_MFLO = 4'd13;

   // Multiply/divide unit operation codes
   localparam logic [2:0] MD_NONE  = 3'd0;
   localparam logic [2:0] MD_MULT  = 3'd1;
   localparam logic [2:0] MD_MULTU = 3'd2;
   localparam logic [2:0] MD_DIV   = 3'd3;
   localparam logic [2:0] MD_DIVU  = 3'd4;
   localparam logic [2:0] MD_MTHI  = 3'd5;
   localparam logic [2:0] MD_MTLO  = 3'd6;

   // Field layout of id_to_ex_bus, MSB first
   typedef struct packed {
      logic [31:0] pc;
      logic [3:0]  alu_op;
      logic [2:0]  md_op;
      logic        data_ram_en;
      logic [3:0]  data_ram_wen;
      logic        sel_rf_res;
      logic        rf_we;
      logic [4:0]  rf_waddr;
      logic [31:0] src_a;
      logic [31:0] src_b;
      logic [31:0] store_data;
   } id_to_ex_t;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_BUSY = 2'd1,
      DIV_DONE = 2'd2
   } div_state_e;

endpackage
`default_nettype wire

// File: rtl/ex_if.sv
`default_nettype none
// ============================================================================
// Module  : ex_if
// Brief   : EX stage bundle: stall/ID inputs, MEM/ID/data-SRAM outputs.
// Revision: 1.0 - initial release
// ============================================================================
interface ex_if;
   import ex_pkg::*;

   logic [STALL_WD-1:0]     stall;
   logic [ID_TO_EX_WD-1:0]  id_to_ex_bus;
   logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
   logic [EX_TO_ID_WD-1:0]  ex_to_id_bus;
   logic                    data_sram_en;
   logic [3:0]              data_sram_wen;
   logic [31:0]             data_sram_addr;
   logic [31:0]             data_sram_wdata;
   logic                    stallreq_for_ex;

   // Pipeline side driving the EX stage
   modport master (
      output stall, id_to_ex_bus,
      input  ex_to_mem_bus, ex_to_id_bus, data_sram_en, data_sram_wen,
             data_sram_addr, data_sram_wdata, stallreq_for_ex
   );

   // EX stage itself
   modport slave (
      input  stall, id_to_ex_bus,
      output ex_to_mem_bus, ex_to_id_bus, data_sram_en, data_sram_wen,
             data_sram_addr, data_sram_wdata, stallreq_for_ex
   );
endinterface
`default_nettype wire

// File: rtl/ex_div.sv
`default_nettype none
// ============================================================================
// Module  : ex_div
// Brief   : 32-iteration radix-2 restoring divider, signed/unsigned.
// Revision: 1.0 - initial release
// ============================================================================
module ex_div
   import ex_pkg::*;
(
   input  wire logic        clk,
   input  wire logic        rst,
   input  wire logic        start,
   input  wire logic        sign_op,
   input  wire logic [31:0] a,
   input  wire logic [31:0] b,
   input  wire logic        ack,
   output logic             busy,
   output logic             done,
   output logic [31:0]      quotient,
   output logic [31:0]      remainder
);

   div_state_e  state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] rem_q, rem_d;
   logic [31:0] quo_q, quo_d;
   logic [31:0] dvs_q, dvs_d;
   logic [31:0] a_q, a_d;
   logic        qneg_q, qneg_d;
   logic        rneg_q, rneg_d;
   logic        dz_q, dz_d;

   logic [31:0] mag_a, mag_b;
   logic [32:0] shifted;
   logic        ge;
   logic [31:0] diff;

   // Operand magnitudes and one restoring trial-subtract step
   always_comb begin
      mag_a   = (sign_op && a[31]) ? (32'd0 - a) : a;
      mag_b   = (sign_op && b[31]) ? (32'd0 - b) : b;
      shifted = {rem_q, quo_q[31]};
      ge      = (shifted >= {1'b0, dvs_q});
      diff    = shifted[31:0] - dvs_q;
   end

   // Next-state: latch operands on start, iterate 32 times, wait for ack
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      a_d     = a_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      dz_d    = dz_q;
      case (state_q)
         DIV_IDLE: begin
            if (start) begin
               state_d = DIV_BUSY;
               cnt_d   = 5'd0;
               rem_d   = 32'd0;
               quo_d   = mag_a;
               dvs_d   = mag_b;
               a_d     = a;
               qneg_d  = sign_op && (a[31] ^ b[31]);
               rneg_d  = sign_op && a[31];
               dz_d    = (b == 32'd0);
            end
         end
         DIV_BUSY: begin
            rem_d = ge ? diff : shifted[31:0];
            quo_d = {quo_q[30:0], ge};
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
               state_d = DIV_DONE;
            end
         end
         DIV_DONE: begin
            if (ack) begin
               state_d = DIV_IDLE;
            end
         end
         default: state_d = DIV_IDLE;
      endcase
   end

   // Divider state and datapath registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= DIV_IDLE;
         cnt_q   <= 5'd0;
         rem_q   <= 32'd0;
         quo_q   <= 32'd0;
         dvs_q   <= 32'd0;
         a_q     <= 32'd0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvs_q   <= dvs_d;
         a_q     <= a_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         dz_q    <= dz_d;
      end
   end

   // Sign fix-up; divide-by-zero returns all-ones quotient and raw dividend
   always_comb begin
      busy      = (state_q == DIV_BUSY);
      done      = (state_q == DIV_DONE);
      quotient  = dz_q ? 32'hFFFF_FFFF : (qneg_q ? (32'd0 - quo_q) : quo_q);
      remainder = dz_q ? a_q : (rneg_q ? (32'd0 - rem_q) : rem_q);
   end

endmodule
`default_nettype wire

// File: rtl/ex.sv
`default_nettype none
// ============================================================================
// Module  : ex
// Brief   : Execute stage: input register, ALU, multiplier, HI/LO, divider.
// Revision: 1.0 - initial release
// ============================================================================
module ex
   import ex_pkg::*;
(
   input wire logic clk,
   input wire logic rst,
   ex_if.slave      bus
);

   id_to_ex_t   ex_q, ex_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;

   logic        advance;
   logic        div_op;
   logic        div_busy, div_done;
   logic [31:0] div_quo, div_rem;
   logic [31:0] ex_result;
   logic [63:0] prod_s, prod_u;
   logic        unused_stall;

   assign unused_stall = ^{bus.stall[5:4], bus.stall[1:0]};
   assign advance      = (bus.stall[STALL_EX] == NO_STOP);
   assign div_op       = (ex_q.md_op == MD_DIV) || (ex_q.md_op == MD_DIVU);

   // Input register: bubble when EX stops but MEM moves on, load, or hold
   always_comb begin
      ex_d = ex_q;
      if (bus.stall[STALL_EX] == STOP && bus.stall[STALL_MEM] == NO_STOP) begin
         ex_d = '0;
      end else if (advance) begin
         ex_d = id_to_ex_t'(bus.id_to_ex_bus);
      end
   end

   // Input register flops
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ex_q <= '0;
      end else begin
         ex_q <= ex_d;
      end
   end

   ex_div u_div (
      .clk       (clk),
      .rst       (rst),
      .start     (div_op),
      .sign_op   (ex_q.md_op == MD_DIV),
      .a         (ex_q.src_a),
      .b         (ex_q.src_b),
      .ack       (advance),
      .busy      (div_busy),
      .done      (div_done),
      .quotient  (div_quo),
      .remainder (div_rem)
   );

   // ALU on registered operands; shifts move src_b by src_a[4:0]
   always_comb begin
      ex_result = 32'd0;
      case (ex_q.alu_op)
         ALU_ADD:  ex_result = ex_q.src_a + ex_q.src_b;
         ALU_SUB:  ex_result = ex_q.src_a - ex_q.src_b;
         ALU_AND:  ex_result = ex_q.src_a & ex_q.src_b;
         ALU_OR:   ex_result = ex_q.src_a | ex_q.src_b;
         ALU_XOR:  ex_result = ex_q.src_a ^ ex_q.src_b;
         ALU_NOR:  ex_result = ~(ex_q.src_a | ex_q.src_b);
         ALU_SLL:  ex_result = ex_q.src_b << ex_q.src_a[4:0];
         ALU_SRL:  ex_result = ex_q.src_b >> ex_q.src_a[4:0];
         ALU_SRA:  ex_result = $signed(ex_q.src_b) >>> ex_q.src_a[4:0];
         ALU_SLT:  ex_result = {31'd0, $signed(ex_q.src_a) < $signed(ex_q.src_b)};
         ALU_SLTU: ex_result = {31'd0, ex_q.src_a < ex_q.src_b};
         ALU_LUI:  ex_result = {ex_q.src_b[15:0], 16'h0000};
         ALU_MFHI: ex_result = hi_q;
         ALU_MFLO: ex_result = lo_q;
         default:  ex_result = 32'd0;
      endcase
   end

   // Single-cycle products; sign-extended operands give the signed result
   always_comb begin
      prod_s = {{32{ex_q.src_a[31]}}, ex_q.src_a} * {{32{ex_q.src_b[31]}}, ex_q.src_b};
      prod_u = {32'd0, ex_q.src_a} * {32'd0, ex_q.src_b};
   end

   // HI/LO commit only when the instruction leaves EX
   always_comb begin
      hi_d = hi_q;
      lo_d = lo_q;
      if (advance) begin
         case (ex_q.md_op)
            MD_MULT:  {hi_d, lo_d} = prod_s;
            MD_MULTU: {hi_d, lo_d} = prod_u;
            MD_DIV, MD_DIVU: begin
               if (div_done) begin
                  hi_d = div_rem;
                  lo_d = div_quo;
               end
            end
            MD_MTHI:  hi_d = ex_q.src_a;
            MD_MTLO:  lo_d = ex_q.src_a;
            default: begin
               hi_d = hi_q;
               lo_d = lo_q;
            end
         endcase
      end
   end

   // HI/LO flops
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hi_q <= 32'd0;
         lo_q <= 32'd0;
      end else begin
         hi_q <= hi_d;
         lo_q <= lo_d;
      end
   end

   // Output buses; an all-zero bubble evaluates to an all-zero result
   always_comb begin
      bus.ex_to_mem_bus   = {ex_q.pc, ex_q.data_ram_en, ex_q.data_ram_wen,
                             ex_q.sel_rf_res, ex_q.rf_we, ex_q.rf_waddr, ex_result};
      bus.ex_to_id_bus    = {ex_q.rf_we, ex_q.rf_waddr, ex_result};
      bus.data_sram_en    = ex_q.data_ram_en;
      bus.data_sram_wen   = ex_q.data_ram_wen;
      bus.data_sram_addr  = ex_result;
      bus.data_sram_wdata = ex_q.store_data;
      bus.stallreq_for_ex = div_busy || (div_op && !div_done);
   end

endmodule
`default_nettype wire

// File: tb/tb_ex.sv
`default_nettype none
// ============================================================================
// Module  : tb_ex
// Brief   : Directed self-checking bench for the EX stage.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ex;
   import ex_pkg::*;

   logic       clk;
   logic       rst;
   logic       use_ovr;
   logic [5:0] stall_ovr;
   int         n_tests;
   int         n_fail;

   ex_if bus_if ();

   ex dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if.slave)
   );

   // Simple hazard controller: a divide stall freezes PC..EX and MEM input
   assign bus_if.stall = use_ovr ? stall_ovr :
                         (bus_if.stallreq_for_ex ? 6'b001111 : 6'b000000);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[14];

   localparam logic [31:0] PC0 = 32'hBFC0_0100;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic id_to_ex_t mk(input logic [3:0] alu, input logic [2:0] md,
                                    input logic [31:0] a, input logic [31:0] b);
      id_to_ex_t t;
      t          = '0;
      t.pc       = PC0;
      t.alu_op   = alu;
      t.md_op    = md;
      t.rf_we    = 1'b1;
      t.rf_waddr = 5'd8;
      t.src_a    = a;
      t.src_b    = b;
      return t;
   endfunction

   // Issue a divide, count stall cycles, optionally hold in DONE, read LO/HI
   task automatic div_seq(input string tag, input logic [2:0] md, input logic [31:0] a,
                          input logic [31:0] b, input int hold,
                          input logic [31:0] exp_lo, input logic [31:0] exp_hi);
      int cnt;
      bus_if.id_to_ex_bus = mk(ALU_ADD, md, a, b);
      step();
      bus_if.id_to_ex_bus = mk(ALU_MFLO, MD_NONE, 32'd0, 32'd0);
      cnt = 0;
      while (bus_if.stallreq_for_ex && cnt < 100) begin
         cnt++;
         step();
      end
      chk({tag, "_stall_cycles"}, cnt, 33);
      use_ovr   = 1'b1;
      stall_ovr = 6'b001111;
      for (int k = 0; k < hold; k++) begin
         step();
         chk({tag, "_hold_no_restart"}, bus_if.stallreq_for_ex, 0);
      end
      use_ovr = 1'b0;
      step();
      chk({tag, "_lo"}, bus_if.ex_to_mem_bus[31:0], exp_lo);
      bus_if.id_to_ex_bus = mk(ALU_MFHI, MD_NONE, 32'd0, 32'd0);
      step();
      chk({tag, "_hi"}, bus_if.ex_to_mem_bus[31:0], exp_hi);
   endtask

   initial begin
      id_to_ex_t st;
      n_tests   = 0;
      n_fail    = 0;
      use_ovr   = 1'b0;
      stall_ovr = 6'b000000;

      vecs[0]  = '{ALU_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000};
      vecs[1]  = '{ALU_SUB,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF};
      vecs[2]  = '{ALU_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000};
      vecs[3]  = '{ALU_OR,   32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0};
      vecs[4]  = '{ALU_XOR,  32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F};
      vecs[5]  = '{ALU_NOR,  32'h0000_0000, 32'h0F0F_0F0F, 32'hF0F0_F0F0};
      vecs[6]  = '{ALU_SLL,  32'h0000_0024, 32'h0000_0001, 32'h0000_0010};
      vecs[7]  = '{ALU_SRL,  32'h0000_0004, 32'h8000_0000, 32'h0800_0000};
      vecs[8]  = '{ALU_SRA,  32'h0000_0004, 32'h8000_0000, 32'hF800_0000};
      vecs[9]  = '{ALU_SLT,  32'hFFFF_FFFB, 32'h0000_0003, 32'h0000_0001};
      vecs[10] = '{ALU_SLTU, 32'hFFFF_FFFB, 32'h0000_0003, 32'h0000_0000};
      vecs[11] = '{ALU_LUI,  32'h0000_0000, 32'h0000_1234, 32'h1234_0000};
      vecs[12] = '{4'd14,    32'h1234_5678, 32'h1111_1111, 32'h0000_0000};
      vecs[13] = '{4'd15,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};

      // Reset: outputs are zero while rst is low, even with live input
      rst = 1'b0;
      bus_if.id_to_ex_bus = mk(ALU_ADD, MD_NONE, 32'd1, 32'd2);
      step();
      step();
      chk("rst_mem_bus",  bus_if.ex_to_mem_bus, 0);
      chk("rst_id_bus",   bus_if.ex_to_id_bus, 0);
      chk("rst_sram_en",  bus_if.data_sram_en, 0);
      chk("rst_stallreq", bus_if.stallreq_for_ex, 0);
      bus_if.id_to_ex_bus = '0;
      rst = 1'b1;

      // ALU vector table
      for (int i = 0; i < 14; i++) begin
         bus_if.id_to_ex_bus = mk(vecs[i].op, MD_NONE, vecs[i].a, vecs[i].b);
         step();
         chk($sformatf("alu_mem_bus[%0d]", i), bus_if.ex_to_mem_bus,
             {PC0, 1'b0, 4'h0, 1'b0, 1'b1, 5'd8, vecs[i].exp});
         chk($sformatf("alu_id_bus[%0d]", i), bus_if.ex_to_id_bus,
             {1'b1, 5'd8, vecs[i].exp});
      end

      // Store request appears in the EX cycle
      st              = '0;
      st.pc           = 32'h0000_2000;
      st.alu_op       = ALU_ADD;
      st.data_ram_en  = 1'b1;
      st.data_ram_wen = 4'hF;
      st.src_a        = 32'h0000_1000;
      st.src_b        = 32'h0000_0004;
      st.store_data   = 32'hDEAD_BEEF;
      bus_if.id_to_ex_bus = st;
      step();
      chk("store_en",    bus_if.data_sram_en, 1);
      chk("store_wen",   bus_if.data_sram_wen, 4'hF);
      chk("store_addr",  bus_if.data_sram_addr, 32'h0000_1004);
      chk("store_wdata", bus_if.data_sram_wdata, 32'hDEAD_BEEF);
      chk("store_mem_bus", bus_if.ex_to_mem_bus,
          {32'h0000_2000, 1'b1, 4'hF, 1'b0, 1'b0, 5'd0, 32'h0000_1004});

      // Hold: EX and MEM both stopped keeps the current instruction
      bus_if.id_to_ex_bus = mk(ALU_ADD, MD_NONE, 32'd5, 32'd6);
      step();
      use_ovr   = 1'b1;
      stall_ovr = 6'b001111;
      bus_if.id_to_ex_bus = mk(ALU_ADD, MD_NONE, 32'd100, 32'd200);
      step();
      chk("hold_result", bus_if.ex_to_mem_bus[31:0], 32'd11);

      // Bubble: EX stopped while MEM moves on clears the stage
      stall_ovr = 6'b000111;
      step();
      chk("bubble_mem_bus", bus_if.ex_to_mem_bus, 0);
      chk("bubble_id_bus",  bus_if.ex_to_id_bus, 0);
      use_ovr = 1'b0;

      // MULTU then back-to-back MFHI/MFLO
      bus_if.id_to_ex_bus = mk(ALU_ADD, MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      step();
      bus_if.id_to_ex_bus = mk(ALU_MFHI, MD_NONE, 32'd0, 32'd0);
      step();
      chk("multu_hi", bus_if.ex_to_mem_bus[31:0], 32'hFFFF_FFFE);
      bus_if.id_to_ex_bus = mk(ALU_MFLO, MD_NONE, 32'd0, 32'd0);
      step();
      chk("multu_lo", bus_if.ex_to_mem_bus[31:0], 32'h0000_0001);

      // Signed MULT -3 * 5 = -15
      bus_if.id_to_ex_bus = mk(ALU_ADD, MD_MULT, 32'hFFFF_FFFD, 32'h0000_0005);
      step();
      bus_if.id_to_ex_bus = mk(ALU_MFHI, MD_NONE, 32'd0, 32'd0);
      step();
      chk("mult_hi", bus_if.ex_to_mem_bus[31:0], 32'hFFFF_FFFF);
      bus_if.id_to_ex_bus = mk(ALU_MFLO, MD_NONE, 32'd0, 32'd0);
      step();
      chk("mult_lo", bus_if.ex_to_mem_bus[31:0], 32'hFFFF_FFF1);

      // MTHI / MTLO
      bus_if.id_to_ex_bus = mk(ALU_ADD, MD_MTHI, 32'h1111_1111, 32'd0);
      step();
      bus_if.id_to_ex_bus = mk(ALU_ADD, MD_MTLO, 32'h2222_2222, 32'd0);
      step();
      bus_if.id_to_ex_bus = mk(ALU_MFHI, MD_NONE, 32'd0, 32'd0);
      step();
      chk("mthi", bus_if.ex_to_mem_bus[31:0], 32'h1111_1111);
      bus_if.id_to_ex_bus = mk(ALU_MFLO, MD_NONE, 32'd0, 32'd0);
      step();
      chk("mtlo", bus_if.ex_to_mem_bus[31:0], 32'h2222_2222);

      // Divides
      div_seq("div_m7_2",    MD_DIV,  32'hFFFF_FFF9, 32'h0000_0002, 0, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
      div_seq("divu_100_0",  MD_DIVU, 32'd100,       32'd0,         3, 32'hFFFF_FFFF, 32'd100);
      div_seq("div_min_m1",  MD_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h8000_0000, 32'h0000_0000);
      div_seq("div_7_m2",    MD_DIV,  32'h0000_0007, 32'hFFFF_FFFE, 1, 32'hFFFF_FFFD, 32'h0000_0001);
      div_seq("divu_100_7",  MD_DIVU, 32'd100,       32'd7,         0, 32'd14,        32'd2);

      // Reset in the middle of a divide (BUSY iteration 10)
      bus_if.id_to_ex_bus = mk(ALU_ADD, MD_DIV, 32'd1000, 32'd3);
      step();
      bus_if.id_to_ex_bus = mk(ALU_MFLO, MD_NONE, 32'd0, 32'd0);
      repeat (11) step();
      chk("rst_mid_busy_stall", bus_if.stallreq_for_ex, 1);
      #1 rst = 1'b0;
      #1;
      chk("rst_mid_stallreq", bus_if.stallreq_for_ex, 0);
      chk("rst_mid_mem_bus",  bus_if.ex_to_mem_bus, 0);
      step();
      rst = 1'b1;
      step();
      chk("rst_after_stallreq", bus_if.stallreq_for_ex, 0);
      chk("rst_after_lo", bus_if.ex_to_mem_bus[31:0], 32'd0);
      bus_if.id_to_ex_bus = mk(ALU_MFHI, MD_NONE, 32'd0, 32'd0);
      step();
      chk("rst_after_hi", bus_if.ex_to_mem_bus[31:0], 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ex.md
EX -- requirements
Module: EX

Interface
REQ-001 Parameters: none; all widths and encodings come from the shared defines header.
REQ-002 clk  in  1  sole clock, rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 stall  in  `StallBus  per-stage stall vector; bit 2 = EX input register, bit 3 = MEM input register; `Stop=1, `NoStop=0.
REQ-005 id_to_ex_bus  in  `ID_TO_EX_WD(147)  fields: pc 146:115, alu_op 114:111, md_op 110:108, data_ram_en 107, data_ram_wen 106:103, sel_rf_res 102, rf_we 101, rf_waddr 100:96, src_a 95:64, src_b 63:32, store_data 31:0.
REQ-006 ex_to_mem_bus  out  `EX_TO_MEM_WD(76)  {pc 75:44, data_ram_en 43, data_ram_wen 42:39, sel_rf_res 38, rf_we 37, rf_waddr 36:32, ex_result 31:0}.
REQ-007 ex_to_id_bus  out  38  forwarding: {rf_we 37, rf_waddr 36:32, ex_result 31:0}.
REQ-008 data_sram_en / data_sram_wen[3:0] / data_sram_addr[31:0] / data_sram_wdata[31:0]  out  data memory request.
REQ-009 stallreq_for_ex  out  1  EX requests pipeline stall (divide in progress).

Function
REQ-010 Input register: rst low -> 0; else stall[2]=Stop and stall[3]=NoStop -> 0 (bubble); else stall[2]=NoStop -> load id_to_ex_bus; else hold.
REQ-011 ALU (combinational on registered fields), alu_op: 0 ADD, 1 SUB (both 32-bit wrap, no overflow trap), 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLL, 7 SRL, 8 SRA (src_b shifted by src_a[4:0]), 9 SLT signed, 10 SLTU (result 0/1), 11 LUI (src_b<<16), 12 MFHI, 13 MFLO, 14-15 -> 0.
REQ-012 Memory request driven in the EX cycle: en=data_ram_en, wen=data_ram_wen, addr=ex_result, wdata=store_data; all 0 for a bubble.
REQ-013 md_op: 0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 none.
REQ-014 MULT/MULTU single-cycle 64-bit product of src_a*src_b -> {HI,LO}; MTHI: HI<=src_a; MTLO: LO<=src_a.
REQ-015 HI/LO update only on the clk edge where stall[2]=NoStop (instruction leaves EX); never for bubbles or held instructions.
REQ-016 MFHI/MFLO read current HI/LO registers; an md_op in the immediately preceding instruction is already visible.
REQ-017 Divider FSM IDLE/BUSY/DONE: IDLE and md_op in {DIV,DIVU} -> BUSY next edge; BUSY runs exactly 32 radix-2 restoring iterations -> DONE; DONE -> IDLE on edge with stall[2]=NoStop, else hold DONE.
REQ-018 stallreq_for_ex=1 when (IDLE and divide op present) or BUSY; 0 in DONE and otherwise; total stall 33 cycles per divide.
REQ-019 DIV signed: divide magnitudes; quotient negated if operand signs differ, remainder takes dividend sign; LO=quotient, HI=remainder; 0x80000000/-1 -> LO=0x80000000, HI=0.
REQ-020 Divide by zero (both): LO=32'hFFFFFFFF, HI=src_a; no exception; still 33-cycle latency.
REQ-021 HI/LO for DIV/DIVU written on DONE->IDLE edge; holding in DONE never restarts the divide.
REQ-022 ex_to_mem_bus / ex_to_id_bus carry registered fields unchanged plus ex_result; a bubble yields all-zero buses.

Reset
REQ-023 rst low asynchronously clears input register, HI, LO, divider datapath, FSM -> IDLE; all outputs 0 while rst low.
REQ-024 rst low mid-divide aborts it; HI/LO stay 0; no stall after release.

Structure
REQ-025 `ID_TO_EX_WD, `EX_TO_MEM_WD, `StallBus, `Stop/`NoStop, alu_op and md_op codes live in the shared defines header.
REQ-026 Divider is sub-module ex_div (start, signed, a, b -> busy, done, quotient, remainder); ALU, MULT, HI/LO stay in EX.

Verification
REQ-027 ADD src_a=0x7FFFFFFF src_b=1 -> ex_result 0x80000000 next cycle; SLT -5,3 -> 1; SLTU same operands -> 0.
REQ-028 Store: data_ram_en=1 wen=4'hF src_a=0x1000 src_b=4 store_data=0xDEADBEEF -> sram en=1, addr=0x1004, wdata=0xDEADBEEF in EX cycle.
REQ-029 DIV src_a=-7 src_b=2 -> stallreq high 33 cycles, then MFLO=0xFFFFFFFD, MFHI=0xFFFFFFFF.
REQ-030 DIVU src_a=100 src_b=0 -> LO=0xFFFFFFFF, HI=100; stall[2] forced Stop 3 extra cycles in DONE -> no restart, HI/LO written once.
REQ-031 MULTU 0xFFFFFFFF*0xFFFFFFFF then MFHI/MFLO back-to-back -> 0xFFFFFFFE, 0x00000001.
REQ-032 stall[2]=Stop, stall[3]=NoStop -> ex_to_mem_bus all 0 next cycle; rst low at BUSY iteration 10 -> FSM IDLE, stallreq 0 immediately.
